// File: rtl/programmable_clock_divider.sv
// Programmable integer clock divider.
// Produces a registered divided clock (clockOut) and a one-cycle strobe
// (period_start) that marks the first cycle of each high phase. A new
// divisor is accepted through a valid/ready handshake. It takes effect only
// at a period boundary, or on the next edge when the output is stopped, so
// the divided clock never produces a runt pulse.
module programmable_clock_divider #(
    parameter int DIV_WIDTH = 8,
    parameter int RESET_DIV = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 div_valid,
    output logic                 div_ready,
    input  logic [DIV_WIDTH-1:0] div_bits,
    output logic                 clockOut,
    output logic                 period_start,
    output logic [DIV_WIDTH-1:0] cur_div
);

    localparam logic [DIV_WIDTH-1:0] ZERO = '0;
    localparam logic [DIV_WIDTH-1:0] ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_WIDTH-1:0] TWO  = {{(DIV_WIDTH-2){1'b0}}, 2'b10};

    // A requested ratio of 1 cannot give a low phase, so it becomes 2.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] req);
        return (req == ONE) ? TWO : req;
    endfunction

    // Length of the high phase: ceil(d/2). One extra bit avoids overflow at the top ratio.
    function automatic logic [DIV_WIDTH:0] half_ceil(input logic [DIV_WIDTH-1:0] d);
        return ({1'b0, d} + {{DIV_WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    localparam logic [DIV_WIDTH-1:0] RESET_D   = clamp_div(DIV_WIDTH'(RESET_DIV));
    // Parking the counter on the last cycle makes the first edge after reset a boundary.
    localparam logic [DIV_WIDTH-1:0] RESET_CNT = (RESET_D == ZERO) ? ZERO : (RESET_D - ONE);

    logic [DIV_WIDTH-1:0] div_active;
    logic [DIV_WIDTH-1:0] div_pend;
    logic                 pend_valid;
    logic [DIV_WIDTH-1:0] cnt;

    logic [DIV_WIDTH-1:0] div_active_next;
    logic [DIV_WIDTH-1:0] div_pend_next;
    logic                 pend_valid_next;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic                 clk_out_next;
    logic                 strobe_next;

    logic running;
    logic boundary;
    logic apply;
    logic xfer;

    // Only one update may be pending; ready is low while reset is asserted.
    assign div_ready = !pend_valid && !reset;
    assign xfer      = div_valid && div_ready;
    assign running   = (div_active != ZERO);
    assign boundary  = running && (cnt == (div_active - ONE));
    // Pending ratio loads at the end of a period, or immediately when stopped.
    assign apply     = pend_valid && (!running || boundary);
    assign cur_div   = div_active;

    // Next-state for counter, active/pending divisor, and both output flops.
    always_comb begin
        div_active_next = div_active;
        div_pend_next   = div_pend;
        pend_valid_next = pend_valid;
        cnt_next        = cnt;

        if (apply) begin
            div_active_next = div_pend;
            cnt_next        = ZERO;
            pend_valid_next = 1'b0;
        end else if (running) begin
            cnt_next = boundary ? ZERO : (cnt + ONE);
        end else begin
            cnt_next = ZERO;
        end

        if (xfer) begin
            div_pend_next   = clamp_div(div_bits);
            pend_valid_next = 1'b1;
        end

        // Outputs are computed from the next counter so they stay aligned with it.
        clk_out_next = (div_active_next != ZERO) && ({1'b0, cnt_next} < half_ceil(div_active_next));
        strobe_next  = (div_active_next != ZERO) && (cnt_next == ZERO);
    end

    // State and output registers; reset drops the output and any pending update.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_active   <= RESET_D;
            cnt          <= RESET_CNT;
            pend_valid   <= 1'b0;
            clockOut     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            div_active   <= div_active_next;
            cnt          <= cnt_next;
            pend_valid   <= pend_valid_next;
            clockOut     <= clk_out_next;
            period_start <= strobe_next;
        end
    end

    // Pending divisor is plain data; it is only consumed when pend_valid is set.
    always_ff @(posedge clock) begin
        div_pend <= div_pend_next;
    end

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Testbench for programmable_clock_divider: directed scenarios followed by
// randomized ratio updates, checked against a period-level reference model.
module tb_programmable_clock_divider;

    localparam int RD = 4;

    logic       clock;
    logic       reset;
    logic       div_valid;
    logic       div_ready;
    logic [7:0] div_bits;
    logic       clockOut;
    logic       period_start;
    logic [7:0] cur_div;

    int vectors = 0;
    int errors  = 0;

    // Reference model: active ratio, position inside the period, pending ratio (-1 = none).
    int m_d    = RD;
    int m_pos  = RD - 1;
    int m_pend = -1;

    // Phase/period monitor state.
    bit per_valid = 0;
    int per_d     = 0;
    int since     = 0;
    int hi        = 0;
    bit prev_out  = 0;

    programmable_clock_divider #(.DIV_WIDTH(8), .RESET_DIV(RD)) dut (
        .clock       (clock),
        .reset       (reset),
        .div_valid   (div_valid),
        .div_ready   (div_ready),
        .div_bits    (div_bits),
        .clockOut    (clockOut),
        .period_start(period_start),
        .cur_div     (cur_div)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit acc;
        bit e_out;
        bit e_ps;
        @(posedge clock);
        acc = div_valid && !reset && (m_pend < 0);
        if (reset) begin
            m_d    = RD;
            m_pos  = (RD == 0) ? 0 : RD - 1;
            m_pend = -1;
        end else begin
            if (m_pend >= 0 && (m_d == 0 || m_pos == m_d - 1)) begin
                m_d    = m_pend;
                m_pos  = 0;
                m_pend = -1;
            end else if (m_d != 0) begin
                m_pos = (m_pos + 1) % m_d;
            end
            if (acc) m_pend = (div_bits == 8'd1) ? 2 : int'(div_bits);
        end
        e_out = !reset && (m_d != 0) && (m_pos < (m_d + 1) / 2);
        e_ps  = !reset && (m_d != 0) && (m_pos == 0);
        #1;
        chk("clockOut", clockOut, e_out);
        chk("period_start", period_start, e_ps);
        chk("cur_div", cur_div, m_d);
        chk("div_ready", div_ready, (!reset && m_pend < 0));

        // Period length and high-phase length against the ratio active at period start.
        if (reset) begin
            per_valid = 0;
            hi        = 0;
            prev_out  = 0;
        end else begin
            since++;
            if (period_start) begin
                if (per_valid) chk("period_len", since, per_d);
                per_valid = 1;
                per_d     = m_d;
                since     = 0;
            end
            if (clockOut) hi = prev_out ? hi + 1 : 1;
            else if (prev_out && per_valid) chk("high_len", hi, (per_d + 1) / 2);
            if (m_d == 0) per_valid = 0;
            prev_out = clockOut;
        end
    endtask

    task automatic offer(input int val);
        div_valid = 1'b1;
        div_bits  = val[7:0];
        tick();
        div_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]  pat8;
        logic [9:0]  pat10;
        logic [11:0] pat12;
        logic [5:0]  pat6;

        reset     = 1'b1;
        div_valid = 1'b0;
        div_bits  = 8'd0;

        // Reset held for three cycles.
        repeat (3) tick();
        chk("rst_out", clockOut, 0);
        chk("rst_ps", period_start, 0);
        chk("rst_div", cur_div, RD);
        chk("rst_ready", div_ready, 0);

        // Release: 1,1,0,0 repeating with strobe on each first 1.
        reset = 1'b0;
        #1;
        chk("ready_release", div_ready, 1);
        pat8 = 8'b11001100;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("pat_rst4", clockOut, pat8[7-i]);
            chk("ps_rst4", period_start, (i % 4 == 0));
        end

        // Stop the output, then program 5 from stopped.
        offer(0);
        for (int i = 0; i < 10 && m_d != 0; i++) tick();
        chk("stopped_div", cur_div, 0);
        offer(5);
        pat10 = 10'b1110011100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("pat_d5", clockOut, pat10[9-i]);
        end
        chk("div5", cur_div, 5);

        // Return to 4, then offer 6 at cnt=1 plus an ignored second offer.
        offer(4);
        for (int i = 0; i < 10 && m_d != 4; i++) tick();
        chk("div4", cur_div, 4);
        for (int i = 0; i < 10 && m_pos != 1; i++) tick();
        offer(6);
        chk("ready_pending", div_ready, 0);
        offer(9);
        pat12 = 12'b111000111000;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("pat_d6", clockOut, pat12[11-i]);
        end
        chk("div6", cur_div, 6);

        // R=1 clamps to 2, R=0 stops, R=3 restarts.
        offer(1);
        for (int i = 0; i < 10 && m_d != 2; i++) tick();
        chk("clamp_div", cur_div, 2);
        repeat (4) tick();
        offer(0);
        for (int i = 0; i < 10 && m_d != 0; i++) tick();
        chk("stop_div", cur_div, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stop_out", clockOut, 0);
            chk("stop_ps", period_start, 0);
        end
        offer(3);
        pat6 = 6'b110110;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("pat_d3", clockOut, pat6[5-i]);
        end

        // Reset at cnt=2 of a D=6 period with an update pending.
        offer(6);
        for (int i = 0; i < 10 && m_d != 6; i++) tick();
        for (int i = 0; i < 10 && m_pos != 0; i++) tick();
        offer(7);
        tick();
        chk("pre_rst_out", clockOut, 1);
        reset = 1'b1;
        tick();
        chk("midrst_out", clockOut, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_div", cur_div, RD);
        chk("post_rst_ready", div_ready, 1);
        repeat (6) tick();

        // Randomized updates with random timing.
        for (int i = 0; i < 3000; i++) begin
            div_valid = ($urandom_range(0, 39) == 0);
            div_bits  = 8'($urandom_range(2, 255));
            tick();
        end
        div_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
